// File: rtl/pc_fetch_unit.sv
// PC stage: holds the PC and runs a single-outstanding instruction-bus fetch.
// Optional misaligned-fetch detection is compiled in with `define PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        stallreq_o,
  output logic        fetch_adel_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;
  logic        adel_q, adel_d;

  logic        issue;
  logic [31:0] issue_pc;
  logic [31:0] pc_adv;

  // Only the PC-hold bit of the controller's stall vector matters here.
  logic unused_stall;
  assign unused_stall = &{1'b0, stall[5:1]};

  assign pc_adv = branch_flag_i ? branch_target_address_i : pc_q + PC_STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= 32'h0;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      valid_q   <= 1'b0;
      adel_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      adel_q    <= adel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    adel_d    = adel_q;
    issue     = 1'b0;
    issue_pc  = pc_q;

    if (flush) begin
      // An unacked request cannot be withdrawn; wait it out in DRAIN.
      pc_d    = new_pc;
      valid_d = 1'b0;
      adel_d  = 1'b0;
      if ((state_q == S_REQ || state_q == S_DRAIN) && !ibus_ack_i) begin
        state_d = S_DRAIN;
      end else begin
        issue    = 1'b1;
        issue_pc = new_pc;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          issue    = 1'b1;
          issue_pc = pc_q;
        end
        S_REQ: begin
          if (ibus_ack_i) begin
            inst_d    = ibus_data_i;
            inst_pc_d = addr_q;
            valid_d   = 1'b1;
            if (stall[0]) begin
              req_d   = 1'b0;
              state_d = S_HOLD;
            end else begin
              pc_d     = pc_adv;
              issue    = 1'b1;
              issue_pc = pc_adv;
            end
          end
        end
        S_HOLD: begin
          if (!stall[0] && !adel_q) begin
            pc_d     = pc_adv;
            issue    = 1'b1;
            issue_pc = pc_adv;
          end
        end
        S_DRAIN: begin
          if (ibus_ack_i) begin
            issue    = 1'b1;
            issue_pc = pc_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (issue) begin
`ifdef PC_ALIGN_CHECK_EN
      // A misaligned PC is reported as a NOP and parks until the next flush.
      if (issue_pc[1:0] != 2'b00) begin
        state_d   = S_HOLD;
        req_d     = 1'b0;
        adel_d    = 1'b1;
        inst_d    = 32'h0;
        inst_pc_d = issue_pc;
        valid_d   = 1'b1;
      end else begin
        state_d = S_REQ;
        req_d   = 1'b1;
        addr_d  = issue_pc;
      end
`else
      state_d = S_REQ;
      req_d   = 1'b1;
      addr_d  = issue_pc;
`endif
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    if ((state_q == S_REQ && !ibus_ack_i) || state_q == S_DRAIN) begin
      stallreq_o = 1'b1;
    end
  end

  assign ibus_req_o   = req_q;
  assign ibus_addr_o  = addr_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = valid_q;
  assign fetch_adel_o = adel_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit against a transaction-level fetch model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] br_tgt;
  logic        ack;
  logic [31:0] data;

  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        stallreq_o;
  logic        fetch_adel_o;

  pc_fetch_unit dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag),
    .branch_target_address_i (br_tgt),
    .ibus_req_o              (ibus_req_o),
    .ibus_addr_o             (ibus_addr_o),
    .ibus_ack_i              (ack),
    .ibus_data_i             (data),
    .pc_o                    (pc_o),
    .inst_o                  (inst_o),
    .inst_pc_o               (inst_pc_o),
    .inst_valid_o            (inst_valid_o),
    .stallreq_o              (stallreq_o),
    .fetch_adel_o            (fetch_adel_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model: the bus has at most one fetch in flight (busy); a flushed fetch
  // becomes stale and its data is thrown away; parked means fetched-but-held.
  logic [31:0] m_pc, m_addr, m_inst, m_ipc;
  logic        m_busy, m_stale, m_parked, m_started, m_ival, m_adel;

  task automatic model_reset();
    m_pc = RST_PC; m_addr = 32'h0; m_inst = 32'h0; m_ipc = 32'h0;
    m_busy = 1'b0; m_stale = 1'b0; m_parked = 1'b0; m_started = 1'b0;
    m_ival = 1'b0; m_adel = 1'b0;
  endtask

  task automatic start_fetch(input logic [31:0] a);
    m_parked = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) begin
      m_busy = 1'b0; m_parked = 1'b1; m_adel = 1'b1;
      m_inst = 32'h0; m_ipc = a; m_ival = 1'b1;
      return;
    end
`endif
    m_busy = 1'b1;
    m_addr = a;
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    nxt = branch_flag ? br_tgt : m_pc + 32'd4;
    if (flush) begin
      m_pc = new_pc; m_ival = 1'b0; m_adel = 1'b0; m_started = 1'b1;
      if (m_busy && !ack) m_stale = 1'b1;
      else begin m_stale = 1'b0; start_fetch(new_pc); end
    end else if (!m_started) begin
      m_started = 1'b1;
      start_fetch(m_pc);
    end else if (m_busy && ack) begin
      if (m_stale) begin
        m_stale = 1'b0;
        start_fetch(m_pc);
      end else begin
        m_inst = data; m_ipc = m_addr; m_ival = 1'b1;
        if (stall[0]) begin m_busy = 1'b0; m_parked = 1'b1; end
        else begin m_pc = nxt; start_fetch(nxt); end
      end
    end else if (m_parked && !stall[0] && !m_adel) begin
      m_pc = nxt;
      start_fetch(nxt);
    end
  endtask

  task automatic check_state();
    chk("pc_o",         pc_o,                  m_pc);
    chk("ibus_req_o",   {31'b0, ibus_req_o},   {31'b0, m_busy});
    chk("ibus_addr_o",  ibus_addr_o,           m_addr);
    chk("inst_o",       inst_o,                m_inst);
    chk("inst_pc_o",    inst_pc_o,             m_ipc);
    chk("inst_valid_o", {31'b0, inst_valid_o}, {31'b0, m_ival});
    chk("fetch_adel_o", {31'b0, fetch_adel_o}, {31'b0, m_adel});
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    a = $urandom();
    case ($urandom_range(0, 9))
      0: a = 32'h80000180;
      1: a = 32'h00400020;
      2: a = 32'hFFFFFFFC;
      3: a = 32'hFFFFFFF8;
      4: a[0] = 1'b1;
      5: a = 32'h00400022;
      default: a[1:0] = 2'b00;
    endcase
    return a;
  endfunction

  task automatic drive_idle();
    stall = 6'h0; flush = 1'b0; new_pc = 32'h0;
    branch_flag = 1'b0; br_tgt = 32'h0; ack = 1'b0; data = 32'h0;
  endtask

  task automatic drive(input int c);
    stall  = 6'($urandom());
    data   = $urandom();
    new_pc = pick_addr();
    br_tgt = pick_addr();
    if (c < 12) begin
      // Clean streaming start: ack every request, no stall, flush or branch.
      stall[0] = 1'b0; flush = 1'b0; branch_flag = 1'b0;
      ack = m_busy;
    end else begin
      stall[0]    = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 24) == 0);
      branch_flag = ($urandom_range(0, 4) == 0);
      ack         = m_busy && ($urandom_range(0, 9) < 6);
    end
  endtask

  // Entered on a falling edge right after reset release.
  task automatic run_phase(input int n);
    for (int c = 0; c < n; c++) begin
      check_state();
      drive(c);
      #1;
      chk("stallreq_o", {31'b0, stallreq_o}, {31'b0, m_busy && (m_stale || !ack)});
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    check_state();
  endtask

  task automatic check_reset_values();
    chk("rst_pc_o",       pc_o,                  RST_PC);
    chk("rst_ibus_req",   {31'b0, ibus_req_o},   32'h0);
    chk("rst_ibus_addr",  ibus_addr_o,           32'h0);
    chk("rst_inst_o",     inst_o,                32'h0);
    chk("rst_inst_pc_o",  inst_pc_o,             32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("rst_fetch_adel", {31'b0, fetch_adel_o}, 32'h0);
    chk("rst_stallreq",   {31'b0, stallreq_o},   32'h0);
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_values();
    @(negedge clk);
    rst = 1'b1;
    run_phase(2500);

    // Asynchronous reset in the middle of traffic, between clock edges.
    #2 rst = 1'b0;
    drive_idle();
    #1 check_reset_values();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    run_phase(2500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
